arrange_stream: RTL and testbench



---
 rtl/arrange_stream_if.sv | 33 +++
 rtl/arrange_stream.sv | 163 ++++++++++++++++
 tb/tb_arrange_stream.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arrange_stream_if.sv
// ============================================================================
// Module   : arrange_stream_if
// Brief    : Input/output valid-ready streams of the batch arranger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arrange_stream_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_even;

  // Producer/consumer side of the block
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_even
  );

  // The arranger itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_even
  );
endinterface

`default_nettype wire

// File: rtl/arrange_stream.sv
// ============================================================================
// Module   : arrange_stream
// Brief    : Loads N values, replays them as evens descending then odds ascending.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arrange_stream #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  arrange_stream_if.slave bus
);

  localparam int            CW         = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST_IDX = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_ne;
  logic [CW-1:0] r_no;
  logic [CW-1:0] r_rd_idx;
  logic [W-1:0]  r_even [N];
  logic [W-1:0]  r_odd  [N];
  logic [W-1:0]  w_even_nxt [N];
  logic [W-1:0]  w_odd_nxt  [N];
  logic [N-1:0]  w_even_keep;
  logic [N-1:0]  w_odd_keep;
  logic [W-1:0]  w_even_sel;
  logic [W-1:0]  w_odd_sel;
  logic [CW-1:0] w_odd_idx;
  logic          w_acc;
  logic          w_dlv;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [W-1:0]  w_out_data;
  logic          w_out_last;
  logic          w_out_even;

  // Slots before the insertion point keep their entry, the insertion slot takes
  // the new value and every later slot takes its left neighbour (shift right).
  generate
    for (genvar i = 0; i < N; i++) begin : g_slot
      localparam logic [CW-1:0] C_IDX = CW'(i);
      assign w_even_keep[i] = (C_IDX < r_ne) && (r_even[i] >= bus.in_data);
      assign w_odd_keep[i]  = (C_IDX < r_no) && (r_odd[i]  <= bus.in_data);
      if (i == 0) begin : g_head
        assign w_even_nxt[i] = w_even_keep[i] ? r_even[i] : bus.in_data;
        assign w_odd_nxt[i]  = w_odd_keep[i]  ? r_odd[i]  : bus.in_data;
      end else begin : g_body
        assign w_even_nxt[i] = w_even_keep[i]   ? r_even[i]   :
                               w_even_keep[i-1] ? bus.in_data : r_even[i-1];
        assign w_odd_nxt[i]  = w_odd_keep[i]    ? r_odd[i]    :
                               w_odd_keep[i-1]  ? bus.in_data : r_odd[i-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int j = 0; j < N; j++) begin
        if (bus.in_data[0]) begin
          r_odd[j] <= w_odd_nxt[j];
        end else begin
          r_even[j] <= w_even_nxt[j];
        end
      end
    end
  end

  always_comb begin
    w_even_sel = '0;
    w_odd_sel  = '0;
    w_odd_idx  = r_rd_idx - r_ne;
    for (int j = 0; j < N; j++) begin
      if (r_rd_idx == CW'(j)) begin
        w_even_sel = r_even[j];
      end
      if (w_odd_idx == CW'(j)) begin
        w_odd_sel = r_odd[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_out_last  = 1'b0;
    w_out_even  = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && ((r_ne + r_no) == C_LAST_IDX)) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_out_valid = 1'b1;
        w_out_even  = (r_rd_idx < r_ne);
        w_out_data  = w_out_even ? w_even_sel : w_odd_sel;
        w_out_last  = (r_rd_idx == C_LAST_IDX);
        if (bus.out_ready && w_out_last) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign w_acc = w_in_ready && bus.in_valid;
  assign w_dlv = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ne     <= '0;
      r_no     <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_acc) begin
        if (bus.in_data[0]) begin
          r_no <= r_no + CW'(1);
        end else begin
          r_ne <= r_ne + CW'(1);
        end
      end
      if (w_dlv) begin
        if (w_out_last) begin
          r_ne     <= '0;
          r_no     <= '0;
          r_rd_idx <= '0;
        end else begin
          r_rd_idx <= r_rd_idx + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_last  = w_out_last;
  assign bus.out_even  = w_out_even;

endmodule

`default_nettype wire

// File: tb/tb_arrange_stream.sv
// ============================================================================
// Module   : tb_arrange_stream
// Brief    : Self-checking bench for arrange_stream against a sort-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arrange_stream;

  localparam int N = 10;
  localparam int W = 4;
  typedef logic [W-1:0] val_t;

  logic clk = 1'b0;
  logic rst_n;

  arrange_stream_if #(.W(W)) bus ();

  arrange_stream #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  val_t got_data [$];
  logic got_even [$];
  logic got_last [$];
  val_t exp_data [$];
  logic exp_even [$];

  int stall_viol;
  int ready_viol;
  int early_viol;
  int load_timeout;
  int emit_timeout;
  int load_cycles;

  val_t mixed_in   [N] = '{3, 8, 1, 6, 0, 7, 2, 9, 4, 5};
  val_t mixed_out  [N] = '{8, 6, 4, 2, 0, 1, 3, 5, 7, 9};
  val_t odd_in     [N] = '{9, 1, 7, 1, 15, 3, 3, 5, 13, 11};
  val_t odd_out    [N] = '{1, 1, 3, 3, 5, 7, 9, 11, 13, 15};
  val_t even_in    [N] = '{0, 14, 2, 14, 8, 6, 10, 4, 12, 0};
  val_t even_out   [N] = '{14, 14, 12, 10, 8, 6, 4, 2, 0, 0};
  val_t reset_in   [N] = '{5, 4, 3, 2, 1, 0, 15, 14, 13, 12};
  val_t reset_out  [N] = '{14, 12, 4, 2, 0, 1, 3, 5, 13, 15};

  // Reference: evens sorted high-to-low, then odds sorted low-to-high
  function automatic void build_model(input val_t vals [N]);
    val_t ev [$];
    val_t od [$];
    for (int i = 0; i < N; i++) begin
      if (vals[i][0]) od.push_back(vals[i]);
      else            ev.push_back(vals[i]);
    end
    ev.rsort();
    od.sort();
    exp_data = {};
    exp_even = {};
    foreach (ev[i]) begin exp_data.push_back(ev[i]); exp_even.push_back(1'b1); end
    foreach (od[i]) begin exp_data.push_back(od[i]); exp_even.push_back(1'b0); end
  endfunction

  function automatic int diff_count();
    int d = 0;
    if (got_data.size() != N) d += 1;
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      if (got_data[i] !== exp_data[i]) d++;
      if (got_even[i] !== exp_even[i]) d++;
      if (got_last[i] !== (i == N - 1)) d++;
    end
    return d;
  endfunction

  function automatic int lit_diff(input val_t want [N]);
    int d = 0;
    if (got_data.size() != N) d += 1;
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      if (got_data[i] !== want[i]) d++;
    end
    return d;
  endfunction

  // Called at a falling edge; returns at the falling edge after the Nth acceptance.
  task automatic load_batch(input val_t vals [N], input int gap_pct);
    int k   = 0;
    int cyc = 0;
    early_viol   = 0;
    load_timeout = 0;
    while (k < N && cyc < 1000) begin
      if (bus.out_valid) early_viol++;
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = val_t'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = vals[k];
      end
      if (bus.in_valid && bus.in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    load_cycles = cyc;
    if (k < N) load_timeout = 1;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic collect(input int mode, input int limit);
    int   cyc     = 0;
    logic stalled = 1'b0;
    logic r;
    val_t pd = '0;
    logic pe = 1'b0;
    logic pl = 1'b0;
    got_data = {};
    got_even = {};
    got_last = {};
    stall_viol   = 0;
    ready_viol   = 0;
    emit_timeout = 0;
    while (got_data.size() < limit && cyc < 1000) begin
      if (stalled && (!bus.out_valid || bus.out_data !== pd ||
                      bus.out_even !== pe || bus.out_last !== pl)) stall_viol++;
      if (bus.out_valid && bus.in_ready) ready_viol++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(1));
      endcase
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        got_data.push_back(bus.out_data);
        got_even.push_back(bus.out_even);
        got_last.push_back(bus.out_last);
      end
      stalled = bus.out_valid && !r;
      pd = bus.out_data;
      pe = bus.out_even;
      pl = bus.out_last;
      @(negedge clk);
      cyc++;
    end
    if (got_data.size() < limit) emit_timeout = 1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0 || bus.out_last !== 1'b0 || bus.out_even !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got data=%0d last=%b even=%b want 0/0/0", bus.out_data, bus.out_last, bus.out_even);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed(input string name, input val_t vin [N], input val_t vout [N]);
    build_model(vin);
    load_batch(vin, 0);
    checks++;
    if (load_timeout != 0 || early_viol != 0) begin
      errors++; $display("FAIL %s_load got timeout=%0d early_valid=%0d want 0/0", name, load_timeout, early_viol);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s_first_valid got %b want 1", name, bus.out_valid); end
    collect(0, N);
    checks++;
    if (emit_timeout != 0 || diff_count() != 0) begin
      errors++; $display("FAIL %s_model got %0d diffs (timeout=%0d) want 0", name, diff_count(), emit_timeout);
    end
    checks++;
    if (lit_diff(vout) != 0) begin
      errors++; $display("FAIL %s_order got %0d diffs against literal want 0", name, lit_diff(vout));
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b want 1", name, bus.in_ready); end
  endtask

  task automatic test_backpressure();
    build_model(mixed_in);
    load_batch(mixed_in, 40);
    checks++;
    if (load_timeout != 0 || early_viol != 0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_load got timeout=%0d early=%0d valid=%b want 0/0/1", load_timeout, early_viol, bus.out_valid);
    end
    collect(1, N);
    checks++;
    if (emit_timeout != 0 || lit_diff(mixed_out) != 0 || diff_count() != 0) begin
      errors++; $display("FAIL bp_order got %0d diffs want 0", diff_count());
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_viol); end
    checks++;
    if (ready_viol != 0) begin errors++; $display("FAIL bp_in_ready_low got %0d violations want 0", ready_viol); end
  endtask

  task automatic test_reset_mid_emit();
    load_batch(mixed_in, 0);
    collect(0, 4);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd0) begin
      errors++; $display("FAIL rme_before got valid=%b data=%0d want 1/0", bus.out_valid, bus.out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0 ||
        bus.out_last !== 1'b0 || bus.out_even !== 1'b0) begin
      errors++;
      $display("FAIL rme_async got valid=%b ready=%b data=%0d last=%b even=%b want 0/1/0/0/0",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_last, bus.out_even);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_fixed("rme_new", reset_in, reset_out);
  endtask

  task automatic test_back_to_back();
    val_t a [N];
    val_t b [N];
    for (int i = 0; i < N; i++) begin
      a[i] = val_t'($urandom);
      b[i] = val_t'($urandom);
    end
    load_batch(a, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = b[0];
    build_model(a);
    collect(0, N);
    checks++;
    if (emit_timeout != 0 || diff_count() != 0 || ready_viol != 0) begin
      errors++; $display("FAIL b2b_first got diffs=%0d ready_viol=%0d want 0/0", diff_count(), ready_viol);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise got %b want 1", bus.in_ready); end
    load_batch(b, 0);
    checks++;
    if (load_cycles != N || load_timeout != 0) begin
      errors++; $display("FAIL b2b_load_cycles got %0d want %0d", load_cycles, N);
    end
    build_model(b);
    collect(0, N);
    checks++;
    if (emit_timeout != 0 || diff_count() != 0) begin
      errors++; $display("FAIL b2b_second got diffs=%0d want 0", diff_count());
    end
  endtask

  task automatic test_random();
    val_t v [N];
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) v[i] = val_t'($urandom);
      build_model(v);
      load_batch(v, 30);
      collect(2, N);
      checks++;
      if (load_timeout != 0 || emit_timeout != 0 || diff_count() != 0 || stall_viol != 0) begin
        errors++;
        $display("FAIL random_%0d got diffs=%0d stall=%0d timeouts=%0d/%0d want 0",
                 t, diff_count(), stall_viol, load_timeout, emit_timeout);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fixed("mixed", mixed_in, mixed_out);
    test_fixed("all_odd", odd_in, odd_out);
    test_fixed("all_even", even_in, even_out);
    test_backpressure();
    test_reset_mid_emit();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
